// File: rtl/ddl_pkg.sv
// Shared constants, types and elaboration helpers for the delay-line lane combiner.
// Lane geometry defaults match DigitalDelayLine_v1_0 so both blocks stay in step.
package ddl_pkg;

  localparam int LANES_DEF  = 16;
  localparam int LANE_W_DEF = 16;

  typedef logic signed [LANE_W_DEF-1:0] lane_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) begin
        r = r + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Width of adder tree level 'level': one growth bit per pairwise add.
  function automatic int sum_w(input int level, input int lane_w = LANE_W_DEF);
    return lane_w + level;
  endfunction

endpackage

// File: rtl/ddl_adder_level.sv
// One registered pairwise-add level of the lane adder tree: N signed inputs of W bits
// become N/2 signed sums of W+1 bits; the valid bit travels with the data.
module ddl_adder_level #(
  parameter int N = 2,
  parameter int W = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     ce,
  input  logic                     in_valid,
  input  logic [N*W-1:0]           in_data,
  output logic                     out_valid,
  output logic [(N/2)*(W+1)-1:0]   out_data
);

  localparam int M = N / 2;

  logic [M*(W+1)-1:0] sum_s;

  // Sign-extend each neighbour pair by one bit and add; the extra bit makes overflow impossible.
  always_comb begin
    logic signed [W:0] a_s;
    logic signed [W:0] b_s;
    sum_s = '0;
    a_s   = '0;
    b_s   = '0;
    for (int i = 0; i < M; i++) begin
      a_s = $signed(in_data[(2*i)*W +: W]);
      b_s = $signed(in_data[(2*i+1)*W +: W]);
      sum_s[i*(W+1) +: W+1] = a_s + b_s;
    end
  end

  // Level register; holds everything while the downstream stall keeps ce low.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ce) begin
      out_valid <= in_valid;
      out_data  <= sum_s;
    end
  end

endmodule

// File: rtl/ddl_lane_summer.sv
// Delay-and-sum combiner: sums all delay-aligned lanes through a registered adder tree,
// integrates DECIM sums and emits one sign-extended result per DECIM accepted beats.
module ddl_lane_summer
  import ddl_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int DECIM  = 4,
  parameter int OUT_W  = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [LANES*LANE_W-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [OUT_W-1:0]        m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready
);

  localparam int L      = clog2(LANES);
  localparam int TREE_W = sum_w(L, LANE_W);
  localparam int CNT_W  = (DECIM > 1) ? clog2(DECIM) : 1;

  if ((1 << L) != LANES || LANES < 2 || LANES > 64) begin : g_bad_lanes
    $error("ddl_lane_summer: LANES must be a power of two in 2..64");
  end
  if (DECIM < 1 || DECIM > 256) begin : g_bad_decim
    $error("ddl_lane_summer: DECIM must be in 1..256");
  end
  if (OUT_W < LANE_W + L + clog2(DECIM)) begin : g_bad_out_w
    $error("ddl_lane_summer: OUT_W too narrow for a wrap-free integrated sum");
  end

  // A single advance enable stalls the whole pipe whenever a result is waiting on downstream.
  logic ce_s;
  assign ce_s          = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = ce_s;

  for (genvar i = 0; i < L; i++) begin : g_lvl
    localparam int N = LANES >> i;
    localparam int W = sum_w(i, LANE_W);

    logic [N*W-1:0]           din_s;
    logic                     vin_s;
    logic [(N/2)*(W+1)-1:0]   data_r;
    logic                     valid_r;

    if (i == 0) begin : g_first
      assign din_s = s_axis_tdata;
      assign vin_s = s_axis_tvalid;
    end else begin : g_next
      assign din_s = g_lvl[i-1].data_r;
      assign vin_s = g_lvl[i-1].valid_r;
    end

    ddl_adder_level #(
      .N (N),
      .W (W)
    ) u_level (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .ce        (ce_s),
      .in_valid  (vin_s),
      .in_data   (din_s),
      .out_valid (valid_r),
      .out_data  (data_r)
    );
  end

  logic signed [TREE_W-1:0] tree_s;
  logic                     tree_valid_s;
  logic signed [OUT_W-1:0]  tree_ext_s;
  logic signed [OUT_W-1:0]  acc_r;
  logic signed [OUT_W-1:0]  acc_sum_s;
  logic [CNT_W-1:0]         cnt_r;

  assign tree_s       = g_lvl[L-1].data_r;
  assign tree_valid_s = g_lvl[L-1].valid_r;
  assign tree_ext_s   = OUT_W'(tree_s);
  assign acc_sum_s    = acc_r + tree_ext_s;

  // Integrate-and-dump plus output register; a handshake and a new load may coincide.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_r         <= '0;
      cnt_r         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (ce_s) begin
      m_axis_tvalid <= 1'b0;
      if (tree_valid_s) begin
        if (cnt_r == CNT_W'(DECIM - 1)) begin
          m_axis_tdata  <= acc_sum_s;
          m_axis_tvalid <= 1'b1;
          acc_r         <= '0;
          cnt_r         <= '0;
        end else begin
          acc_r <= acc_sum_s;
          cnt_r <= cnt_r + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddl_lane_summer.sv
// Scoreboard bench: two instances (DECIM=1 and DECIM=4) share the input stream; a reference
// model built from plain lane sums queues expected results and a monitor checks every handshake.
module tb_ddl_lane_summer;

  localparam int LANES = 16;
  localparam int LW    = 16;
  localparam int OW    = 32;
  localparam int DW    = LANES * LW;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready1, s_tready4;
  logic [OW-1:0] m_tdata1, m_tdata4;
  logic          m_tvalid1, m_tvalid4;
  logic          m_tready1 = 1'b1;
  logic          m_tready4 = 1'b1;

  always #5 aclk = ~aclk;

  ddl_lane_summer #(.LANES(LANES), .LANE_W(LW), .DECIM(1), .OUT_W(OW)) u_dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready1),
    .m_axis_tdata(m_tdata1), .m_axis_tvalid(m_tvalid1), .m_axis_tready(m_tready1));

  ddl_lane_summer #(.LANES(LANES), .LANE_W(LW), .DECIM(4), .OUT_W(OW)) u_dut4 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready4),
    .m_axis_tdata(m_tdata4), .m_axis_tvalid(m_tvalid4), .m_axis_tready(m_tready4));

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  int q1[$];
  int q4[$];
  int acc4 = 0, cnt4 = 0;
  int beats4 = 0, pops4 = 0, last_val4 = 0;
  int last1 = -1, last4 = -1, gap1 = 0, gap4 = 0;
  int first_acc1 = -1, first_vld1 = -1;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lane_sum(input logic [DW-1:0] d);
    int s;
    logic signed [LW-1:0] v;
    s = 0;
    for (int k = 0; k < LANES; k++) begin
      v = d[k*LW +: LW];
      s += int'(v);
    end
    return s;
  endfunction

  // Delay-line pattern: lanes 0-7 and 8-15 both start at 0..7; beat b shifts them +b / -b.
  function automatic logic [DW-1:0] pattern(input int b);
    logic [DW-1:0] d;
    for (int k = 0; k < 8; k++) begin
      d[k*LW +: LW]     = LW'(k + b);
      d[(k+8)*LW +: LW] = LW'(k - b);
    end
    return d;
  endfunction

  function automatic logic [DW-1:0] all_lanes(input logic [LW-1:0] v);
    logic [DW-1:0] d;
    for (int k = 0; k < LANES; k++) d[k*LW +: LW] = v;
    return d;
  endfunction

  // Monitor: accepted beats feed the reference model, handshakes are checked against it.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (s_tvalid && s_tready1) begin
        if (first_acc1 < 0) first_acc1 = cyc;
        q1.push_back(lane_sum(s_tdata));
      end
      if (s_tvalid && s_tready4) begin
        beats4++;
        acc4 += lane_sum(s_tdata);
        cnt4++;
        if (cnt4 == 4) begin
          q4.push_back(acc4);
          acc4 = 0;
          cnt4 = 0;
        end
      end
      if (m_tvalid1 && first_vld1 < 0) first_vld1 = cyc;
      if (m_tvalid1 && m_tready1) begin
        if (q1.size() == 0) begin
          vectors++; errors++;
          $display("FAIL out1_extra: got %0d, expected no result", int'($signed(m_tdata1)));
        end else begin
          check("out1", int'($signed(m_tdata1)), q1.pop_front());
        end
        if (gap1 != 0 && last1 >= 0) check("gap1", cyc - last1, gap1);
        last1 = cyc;
      end
      if (m_tvalid4 && m_tready4) begin
        pops4++;
        last_val4 = int'($signed(m_tdata4));
        if (q4.size() == 0) begin
          vectors++; errors++;
          $display("FAIL out4_extra: got %0d, expected no result", last_val4);
        end else begin
          check("out4", last_val4, q4.pop_front());
        end
        if (gap4 != 0 && last4 >= 0) check("gap4", cyc - last4, gap4);
        last4 = cyc;
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_phase(input int g1, input int g4);
    gap1 = g1; gap4 = g4; last1 = -1; last4 = -1;
    beats4 = 0; pops4 = 0;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    m_tready1 = 1'b1;
    m_tready4 = 1'b1;
    aresetn = 1'b0;
    repeat (3) step();
    check("rst_tvalid1", int'(m_tvalid1), 0);
    check("rst_tvalid4", int'(m_tvalid4), 0);
    check("rst_tdata1", int'(m_tdata1), 0);
    check("rst_tdata4", int'(m_tdata4), 0);
    check("rst_tready4", int'(s_tready4), 1);
    q1.delete(); q4.delete();
    acc4 = 0; cnt4 = 0;
    first_acc1 = -1; first_vld1 = -1;
    aresetn = 1'b1;
    step();
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    m_tready1 = 1'b1;
    m_tready4 = 1'b1;
    repeat (12) step();
    check("drain_q1", q1.size(), 0);
    check("drain_q4", q4.size(), 0);
  endtask

  initial begin
    bit found;
    logic [OW-1:0] held;

    // Continuous delay-line pattern: 56 per beat, 224 per group of four.
    do_reset();
    set_phase(1, 4);
    for (int b = 0; b < 40; b++) begin
      s_tdata = pattern(b);
      s_tvalid = 1'b1;
      step();
    end
    drain();
    check("latency1", first_vld1 - first_acc1, 5);

    // Lane extremes must sum exactly.
    set_phase(1, 4);
    for (int b = 0; b < 8; b++) begin
      s_tdata = (b < 4) ? all_lanes(16'h8000) : all_lanes(16'h7FFF);
      s_tvalid = 1'b1;
      step();
    end
    drain();

    // Downstream stall on the DECIM=4 instance right after its first result.
    set_phase(0, 0);
    found = 1'b0;
    for (int b = 0; b < 30 && !found; b++) begin
      s_tdata = pattern(b);
      s_tvalid = 1'b1;
      step();
      if (m_tvalid4) found = 1'b1;
    end
    check("stall_found", int'(found), 1);
    m_tready4 = 1'b0;
    held = m_tdata4;
    check("stall_first", int'($signed(held)), 224);
    for (int i = 0; i < 20; i++) begin
      s_tdata = pattern(i + 7);
      step();
      check("stall_tdata", int'(m_tdata4), int'(held));
      check("stall_tvalid", int'(m_tvalid4), 1);
      check("stall_tready", int'(s_tready4), 0);
    end
    m_tready4 = 1'b1;
    for (int b = 0; b < 12; b++) begin
      s_tdata = pattern(b);
      step();
    end
    drain();
    check("stall_count", pops4, beats4 / 4);

    // Alternating input valid: bubbles must not advance the group counter.
    do_reset();
    set_phase(2, 8);
    s_tdata = all_lanes(16'd1);
    for (int i = 0; i < 32; i++) begin
      s_tvalid = (i % 2 == 0);
      step();
    end
    drain();
    check("toggle_count", pops4, 4);

    // Reset in the middle of a group discards the partial sum.
    do_reset();
    s_tdata = all_lanes(16'd1);
    s_tvalid = 1'b1;
    repeat (2) step();
    s_tvalid = 1'b0;
    step();
    do_reset();
    set_phase(0, 0);
    s_tvalid = 1'b1;
    repeat (4) step();
    drain();
    check("midrst_count", pops4, 1);
    check("midrst_value", last_val4, 64);

    // Randomised traffic with random backpressure on both instances.
    do_reset();
    set_phase(0, 0);
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < LANES; k++) s_tdata[k*LW +: LW] = LW'($urandom);
      s_tvalid = ($urandom_range(0, 3) != 0);
      m_tready1 = ($urandom_range(0, 3) != 0);
      m_tready4 = ($urandom_range(0, 2) != 0);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
